// File: rtl/ripple_count_monitor.sv
// Step checker for a free-running counter: classifies each sampled value against the
// previous one, counts terminal-count wraps and offers each wrap over a valid/ready slot.
module ripple_count_monitor #(
    parameter int unsigned W    = 4,
    parameter int unsigned TERM = (1 << W) - 1,
    parameter int unsigned CW   = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [W-1:0]  cnt_in,
    input  logic          evt_ready,
    output logic          wrap_pulse,
    output logic          restart_pulse,
    output logic          seq_err,
    output logic          in_fault,
    output logic [CW-1:0] wraps,
    output logic          evt_valid,
    output logic [CW-1:0] evt_data,
    output logic          evt_ovf
);

    typedef enum logic [1:0] {
        StSync,
        StTrack,
        StFault
    } state_e;

    localparam logic [W:0] TermX = (W + 1)'(TERM);

    state_e         state;
    logic [W-1:0]   s_q;
    logic           s_vld;
    logic [W-1:0]   prev;

    logic [W:0]     prev_x;
    logic [W:0]     s_x;
    logic [W:0]     prev_inc;
    logic           s_zero;
    logic           is_hold;
    logic           is_step;
    logic           trk_wrap;
    logic           trk_restart;
    logic           trk_err;
    logic           flt_exit;
    logic           slot_free;
    logic [CW-1:0]  wraps_inc;

    // Extra MSB keeps prev = 2**W-1 from aliasing its successor onto 0.
    always_comb begin
        prev_x      = {1'b0, prev};
        s_x         = {1'b0, s_q};
        prev_inc    = prev_x + (W + 1)'(1);
        s_zero      = (s_q == '0);
        is_hold     = (s_q == prev);
        is_step     = (prev_x < TermX) && (s_x == prev_inc);
        trk_wrap    = !is_hold && (prev_x == TermX) && s_zero;
        trk_restart = !is_hold && s_zero && (prev_x != TermX);
        trk_err     = !is_hold && !is_step && !trk_wrap && !trk_restart;
        flt_exit    = s_zero && (prev != '0);
        slot_free   = !evt_valid || evt_ready;
        wraps_inc   = wraps + CW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= StSync;
            s_q           <= '0;
            s_vld         <= 1'b0;
            prev          <= '0;
            wrap_pulse    <= 1'b0;
            restart_pulse <= 1'b0;
            seq_err       <= 1'b0;
            in_fault      <= 1'b0;
            wraps         <= '0;
            evt_valid     <= 1'b0;
            evt_data      <= '0;
            evt_ovf       <= 1'b0;
        end else begin
            s_q           <= cnt_in;
            s_vld         <= 1'b1;
            wrap_pulse    <= 1'b0;
            restart_pulse <= 1'b0;
            seq_err       <= 1'b0;

            // A wrap below overrides this when it refills the slot in the same cycle.
            if (evt_valid && evt_ready) begin
                evt_valid <= 1'b0;
            end

            case (state)
                StSync: begin
                    if (s_vld) begin
                        prev  <= s_q;
                        state <= StTrack;
                    end
                end
                StTrack: begin
                    prev <= s_q;
                    if (trk_wrap) begin
                        wrap_pulse <= 1'b1;
                        wraps      <= wraps_inc;
                        if (slot_free) begin
                            evt_valid <= 1'b1;
                            evt_data  <= wraps_inc;
                        end else begin
                            evt_ovf <= 1'b1;
                        end
                    end
                    if (trk_restart) begin
                        restart_pulse <= 1'b1;
                    end
                    if (trk_err) begin
                        seq_err  <= 1'b1;
                        in_fault <= 1'b1;
                        state    <= StFault;
                    end
                end
                StFault: begin
                    prev <= s_q;
                    if (flt_exit) begin
                        restart_pulse <= 1'b1;
                        in_fault      <= 1'b0;
                        state         <= StTrack;
                    end
                end
                default: begin
                    state <= StSync;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ripple_count_monitor.sv
// Directed bench for ripple_count_monitor: default 4-bit wrap at 15 plus a TERM=9 instance.
module tb_ripple_count_monitor;

    logic       clk = 1'b1;
    logic       reset = 1'b1;
    logic [3:0] cnt_in = 4'd0;
    logic       evt_ready = 1'b0;
    logic       wrap_pulse, restart_pulse, seq_err, in_fault, evt_valid, evt_ovf;
    logic [7:0] wraps, evt_data;

    logic [3:0] cnt9 = 4'd0;
    logic       wrap9, restart9, err9, fault9, valid9, ovf9;
    logic [7:0] wraps9, data9;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    ripple_count_monitor dut (
        .clk           (clk),
        .reset         (reset),
        .cnt_in        (cnt_in),
        .evt_ready     (evt_ready),
        .wrap_pulse    (wrap_pulse),
        .restart_pulse (restart_pulse),
        .seq_err       (seq_err),
        .in_fault      (in_fault),
        .wraps         (wraps),
        .evt_valid     (evt_valid),
        .evt_data      (evt_data),
        .evt_ovf       (evt_ovf)
    );

    ripple_count_monitor #(.W(4), .TERM(9), .CW(8)) dut9 (
        .clk           (clk),
        .reset         (reset),
        .cnt_in        (cnt9),
        .evt_ready     (1'b1),
        .wrap_pulse    (wrap9),
        .restart_pulse (restart9),
        .seq_err       (err9),
        .in_fault      (fault9),
        .wraps         (wraps9),
        .evt_valid     (valid9),
        .evt_data      (data9),
        .evt_ovf       (ovf9)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // exp = {wrap, restart, err}
    task automatic chk_p(input string tag, input logic [2:0] exp);
        logic [2:0] obs;
        obs = {wrap_pulse, restart_pulse, seq_err};
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed w/r/e=%b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_p9(input string tag, input logic [2:0] exp);
        logic [2:0] obs;
        obs = {wrap9, restart9, err9};
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed w/r/e=%b expected %b", tag, obs, exp);
        end
    endtask

    // Drive v on a falling edge; two falling edges later its classification is visible.
    task automatic step(input logic [3:0] v);
        @(negedge clk);
        cnt_in = v;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic step9(input logic [3:0] v);
        @(negedge clk);
        cnt9 = v;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        // Reset state
        #14;
        chk_p("reset pulses", 3'b000);
        chk1("reset in_fault", in_fault, 1'b0);
        chk8("reset wraps", wraps, 8'd0);
        chk1("reset evt_valid", evt_valid, 1'b0);
        chk8("reset evt_data", evt_data, 8'd0);
        chk1("reset evt_ovf", evt_ovf, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk_p("sync quiet", 3'b000);

        // 1: one full count with consumer stalled
        for (int v = 1; v <= 15; v++) begin
            step(4'(v));
            chk_p("t1 count", 3'b000);
        end
        step(4'd0);
        chk_p("t1 wrap", 3'b100);
        chk8("t1 wraps", wraps, 8'd1);
        chk1("t1 evt_valid", evt_valid, 1'b1);
        chk8("t1 evt_data", evt_data, 8'd1);
        @(negedge clk);
        chk_p("t1 pulse width", 3'b000);

        // 2: two more wraps while the slot is held
        for (int n = 2; n <= 3; n++) begin
            for (int v = 1; v <= 15; v++) step(4'(v));
            step(4'd0);
            chk_p("t2 wrap", 3'b100);
            chk8("t2 wraps", wraps, 8'(n));
            chk8("t2 evt_data held", evt_data, 8'd1);
            chk1("t2 evt_ovf", evt_ovf, 1'b1);
            chk1("t2 evt_valid", evt_valid, 1'b1);
        end
        evt_ready = 1'b1;
        @(negedge clk);
        chk1("t2 drained", evt_valid, 1'b0);
        chk8("t2 data after drain", evt_data, 8'd1);

        // 3: counter cleared at 9
        for (int v = 1; v <= 9; v++) step(4'(v));
        step(4'd0);
        chk_p("t3 restart", 3'b010);
        chk8("t3 wraps", wraps, 8'd3);
        for (int v = 1; v <= 3; v++) begin
            step(4'(v));
            chk_p("t3 resume", 3'b000);
        end

        // 4: illegal jump, fault, recovery
        step(4'd4);
        step(4'd5);
        step(4'd8);
        chk_p("t4 jump", 3'b001);
        chk1("t4 in_fault", in_fault, 1'b1);
        for (int v = 9; v <= 15; v++) begin
            step(4'(v));
            chk_p("t4 in fault", 3'b000);
        end
        chk1("t4 still fault", in_fault, 1'b1);
        step(4'd0);
        chk_p("t4 exit restart", 3'b010);
        chk1("t4 fault cleared", in_fault, 1'b0);
        chk8("t4 wraps kept", wraps, 8'd3);
        for (int v = 1; v <= 15; v++) step(4'(v));
        step(4'd0);
        chk_p("t4 wrap", 3'b100);
        chk8("t4 wraps", wraps, 8'd4);
        chk1("t4 evt_valid", evt_valid, 1'b1);
        chk8("t4 evt_data", evt_data, 8'd4);
        @(negedge clk);
        chk1("t4 taken", evt_valid, 1'b0);

        // 5: hold, then TERM=9 instance
        for (int v = 1; v <= 7; v++) step(4'(v));
        repeat (4) begin
            @(negedge clk);
            chk_p("t5 hold", 3'b000);
        end
        for (int v = 1; v <= 9; v++) step9(4'(v));
        chk_p9("t5 at term", 3'b000);
        step9(4'd0);
        chk_p9("t5 term9 wrap", 3'b100);
        chk8("t5 wraps9", wraps9, 8'd1);
        chk8("t5 data9", data9, 8'd1);
        for (int v = 1; v <= 9; v++) step9(4'(v));
        step9(4'd10);
        chk_p9("t5 beyond term", 3'b001);
        chk1("t5 fault9", fault9, 1'b1);

        // 6: async reset with a pending event and sticky overflow
        evt_ready = 1'b0;
        for (int n = 0; n < 2; n++) begin
            for (int v = (n == 0) ? 8 : 1; v <= 15; v++) step(4'(v));
            step(4'd0);
        end
        chk8("t6 wraps", wraps, 8'd6);
        chk1("t6 evt_valid", evt_valid, 1'b1);
        chk1("t6 evt_ovf", evt_ovf, 1'b1);
        chk8("t6 evt_data", evt_data, 8'd5);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk8("t6 async wraps", wraps, 8'd0);
        chk1("t6 async evt_valid", evt_valid, 1'b0);
        chk1("t6 async evt_ovf", evt_ovf, 1'b0);
        chk8("t6 async evt_data", evt_data, 8'd0);
        chk_p("t6 async pulses", 3'b000);
        cnt_in = 4'd5;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk_p("t6 first sample", 3'b000);
        end
        for (int v = 6; v <= 15; v++) step(4'(v));
        chk_p("t6 tracking", 3'b000);
        step(4'd0);
        chk_p("t6 wrap after reset", 3'b100);
        chk8("t6 wraps after reset", wraps, 8'd1);
        chk8("t6 evt_data after reset", evt_data, 8'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
